// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and K-estimate helper for the DDS measurement blocks.
package dds_pkg;

    localparam int unsigned DW  = 10;   // sample width, offset binary
    localparam int unsigned MID = 512;  // midscale crossing level
    localparam int unsigned HW  = 9;    // hysteresis half-width
    localparam int unsigned KW  = 32;   // tuning word width

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_e;

    // A window of 2^gate_log2 samples holding cnt rising crossings gives K = cnt * 2^(32-gate_log2).
    function automatic logic [KW-1:0] count_to_k(input logic [KW-1:0] cnt,
                                                 input int unsigned  gate_log2);
        return cnt << (KW - gate_log2);
    endfunction

endpackage

// File: rtl/dds_schmitt_edge.sv
// Registered input stage, hysteresis comparator and rising-edge pulse around midscale.
module dds_schmitt_edge
    import dds_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] sample_i,
    input  logic [HW-1:0] hyst_i,
    output logic          valid_o,
    output logic          rise_o
);

    localparam int unsigned CW = DW + 1;

    logic [DW-1:0] sample_q;
    logic          sval_q;
    logic          lvl_q;
    logic          lvl_d;
    logic          rise_q;
    logic          valid_q;
    logic [CW-1:0] hi_c;
    logic [CW-1:0] lo_c;
    logic [CW-1:0] smp_c;

    // Thresholds one bit wider than the sample so MID +/- hyst never wraps; set wins on a tie.
    always_comb begin
        hi_c  = CW'(MID) + CW'(hyst_i);
        lo_c  = CW'(MID) - CW'(hyst_i);
        smp_c = CW'(sample_q);
        lvl_d = lvl_q;
        if (sval_q) begin
            if (smp_c >= hi_c) begin
                lvl_d = 1'b1;
            end else if (smp_c <= lo_c) begin
                lvl_d = 1'b0;
            end
        end
    end

    // Input register, Schmitt level, and rise/valid aligned two cycles after the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            sval_q   <= 1'b0;
            lvl_q    <= 1'b0;
            rise_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= sample_i;
            sval_q   <= sample_valid_i;
            lvl_q    <= lvl_d;
            rise_q   <= ~lvl_q & lvl_d;
            valid_q  <= sval_q;
        end
    end

    assign valid_o = valid_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Gated rising-crossing counter that estimates a DDS tuning word without a divider.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned GATE_LOG2 = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic [DW-1:0]        sample,
    input  logic [HW-1:0]        hyst,
    output logic                 busy,
    output logic                 done,
    output logic [KW-1:0]        k_est,
    output logic [GATE_LOG2-1:0] cross_cnt,
    output logic                 no_signal
);

    localparam int unsigned     GW        = GATE_LOG2;
    localparam logic [GW-1:0]   GATE_LAST = '1;

    state_e          state_q, state_d;
    logic [GW-1:0]   gate_q, gate_d;
    logic [GW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hyst_q, hyst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [KW-1:0]   k_q, k_d;
    logic [GW-1:0]   cross_q, cross_d;
    logic            nosig_q, nosig_d;
    logic            valid_c;
    logic            rise_c;

    dds_schmitt_edge u_edge (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid_i (sample_valid),
        .sample_i       (sample),
        .hyst_i         (hyst_q),
        .valid_o        (valid_c),
        .rise_o         (rise_c)
    );

    // Next-state and result logic: arm on the first rise, then count rises over the gate window.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        hyst_d  = hyst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        k_d     = k_q;
        cross_d = cross_q;
        nosig_d = nosig_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    gate_d  = '0;
                    cnt_d   = '0;
                    hyst_d  = hyst;
                end
            end
            ARM: begin
                if (valid_c) begin
                    if (rise_c) begin
                        state_d = MEASURE;
                        gate_d  = '0;
                        cnt_d   = '0;
                    end else if (gate_q == GATE_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        nosig_d = 1'b1;
                        k_d     = '0;
                        cross_d = '0;
                    end else begin
                        gate_d = gate_q + GW'(1);
                    end
                end
            end
            MEASURE: begin
                if (valid_c) begin
                    cnt_d = cnt_q + GW'(rise_c);
                    if (gate_q == GATE_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        nosig_d = 1'b0;
                        cross_d = cnt_d;
                        k_d     = count_to_k(KW'(cnt_d), GATE_LOG2);
                    end else begin
                        gate_d = gate_q + GW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            hyst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            k_q     <= '0;
            cross_q <= '0;
            nosig_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            hyst_q  <= hyst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            k_q     <= k_d;
            cross_q <= cross_d;
            nosig_q <= nosig_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign k_est     = k_q;
    assign cross_cnt = cross_q;
    assign no_signal = nosig_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Randomized bench for dds_freq_meter against a sample-list crossing model.
module tb_dds_freq_meter;

    localparam int unsigned G      = 10;
    localparam int          WIN    = 1 << G;
    localparam int          MIDV   = 512;
    localparam int          BUDGET = 8000;
    localparam real         PI     = 3.14159265358979;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sample_valid;
    logic [9:0]    sample;
    logic [8:0]    hyst;
    logic          busy;
    logic          done;
    logic [31:0]   k_est;
    logic [G-1:0]  cross_cnt;
    logic          no_signal;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: Schmitt level over the valid-sample stream, plus per-sample rise log after start.
    bit          m_lvl;
    int          m_hyst;
    bit          recording;
    bit          rise_log[$];
    logic [31:0] ph;
    bit          dith;

    dds_freq_meter #(.GATE_LOG2(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .hyst         (hyst),
        .busy         (busy),
        .done         (done),
        .k_est        (k_est),
        .cross_cnt    (cross_cnt),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    // Waveform source: 0 = DDS sine (+noise), 1 = constant midscale, 2 = small dither around midscale.
    function automatic logic [9:0] wave(input logic [31:0] k, input int mode, input int noise);
        int v;
        if (mode == 1) return 10'd512;
        if (mode == 2) begin
            dith = ~dith;
            return dith ? 10'd515 : 10'd509;
        end
        v  = MIDV + int'(511.0 * $sin(2.0 * PI * real'(ph) / 4294967296.0));
        ph = ph + k;
        if (noise > 0) v = v + int'($urandom_range(32'(2 * noise))) - noise;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return 10'(v);
    endfunction

    function automatic void model_sample(input logic [9:0] s);
        int si;
        bit nl;
        si = int'(s);
        nl = m_lvl;
        if (si >= MIDV + m_hyst) nl = 1'b1;
        else if (si <= MIDV - m_hyst) nl = 1'b0;
        if (recording) rise_log.push_back(!m_lvl && nl);
        m_lvl = nl;
    endfunction

    function automatic void model_reset();
        m_lvl     = 1'b0;
        m_hyst    = 0;
        recording = 1'b0;
        rise_log.delete();
    endfunction

    // One clock: drive at the falling edge, let the rising edge pass, return at the next falling edge.
    task automatic step(input bit v, input logic [9:0] s, input bit st, input logic [8:0] h, input bit accept);
        sample_valid = v;
        sample       = s;
        start        = st;
        hyst         = h;
        if (accept) begin
            m_hyst    = int'(h);
            recording = 1'b1;
            rise_log.delete();
        end
        if (v) model_sample(s);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one measurement, returning observed results and the model's expected results.
    task automatic run_meas(input logic [31:0] k, input int mode, input int noise, input int hy,
                            input int vpct, input bit poke,
                            output int o_cnt, output logic [31:0] o_k, output bit o_ns, output int o_len,
                            output int o_pulses, output int o_busy_bad, output int o_steps,
                            output int e_cnt, output bit e_ns, output int e_len);
        int vh[$];
        bit seen;
        bit v;
        logic [9:0] s;
        int d;
        int arm;
        o_cnt = 0; o_k = '0; o_ns = 1'b0; o_len = -1;
        o_pulses = 0; o_busy_bad = 0; o_steps = 0;
        step(1'b0, 10'd0, 1'b0, 9'(hy), 1'b0);
        step(1'b0, 10'd0, 1'b0, 9'(hy), 1'b0);
        step(1'b0, 10'd0, 1'b1, 9'(hy), 1'b1);
        seen = 1'b0;
        d    = 0;
        while (!seen && o_steps < BUDGET) begin
            if (done === 1'b1) begin
                seen     = 1'b1;
                o_pulses = 1;
                o_cnt    = int'(cross_cnt);
                o_k      = k_est;
                o_ns     = no_signal;
                if (busy !== 1'b0) o_busy_bad++;
                d = vh.size();
            end else begin
                if (busy !== 1'b1) o_busy_bad++;
                v = (int'($urandom_range(99)) < vpct);
                s = v ? wave(k, mode, noise) : 10'($urandom_range(1023));
                step(v, s, poke && (o_steps == 5 || o_steps == 300 || o_steps == 900),
                     9'($urandom_range(511)), 1'b0);
                vh.push_back(int'(v));
                o_steps++;
            end
        end
        recording = 1'b0;
        if (seen) begin
            o_len = 0;
            for (int i = 0; i < d - 2; i++) o_len += vh[i];
            step(1'b1, wave(k, mode, noise), poke, 9'($urandom_range(511)), 1'b0);
            if (done === 1'b1) o_pulses++;
            if (busy !== 1'b0) o_busy_bad++;
            step(1'b1, wave(k, mode, noise), 1'b0, 9'($urandom_range(511)), 1'b0);
            if (done === 1'b1) o_pulses++;
            if (busy !== 1'b0) o_busy_bad++;
        end
        e_cnt = 0; e_ns = 1'b1; e_len = WIN; arm = -1;
        for (int i = 0; i < WIN && i < rise_log.size(); i++) begin
            if (rise_log[i]) begin
                arm = i;
                break;
            end
        end
        if (arm >= 0) begin
            e_ns  = 1'b0;
            e_len = arm + 1 + WIN;
            for (int i = arm + 1; i < arm + 1 + WIN && i < rise_log.size(); i++) e_cnt += int'(rise_log[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = '0; hyst = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || no_signal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: busy/done/no_signal got %b%b%b want 000", busy, done, no_signal);
        end
        n_cmp++;
        if (k_est !== 32'h0 || cross_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_results: k_est=%h cross_cnt=%0d want 0 0", k_est, cross_cnt);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_clean_sine();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        ph = '0;
        run_meas(32'h0400_0000, 0, 0, 8, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != 16 || oc != ec) begin n_bad++; $display("FAIL sine_cross_cnt: got %0d want 16 (model %0d)", oc, ec); end
        n_cmp++;
        if (ok !== 32'h0400_0000) begin n_bad++; $display("FAIL sine_k_est: got %h want 04000000", ok); end
        n_cmp++;
        if (ons !== 1'b0) begin n_bad++; $display("FAIL sine_no_signal: got %b want 0", ons); end
        n_cmp++;
        if (ol != el) begin n_bad++; $display("FAIL sine_window_len: got %0d valid samples want %0d", ol, el); end
        n_cmp++;
        if (op != 1 || ob != 0) begin n_bad++; $display("FAIL sine_handshake: done pulses %0d busy errors %0d want 1 0", op, ob); end
    endtask

    task automatic test_no_signal();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        run_meas(32'h0, 1, 0, 8, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (ons !== 1'b1 || ens !== 1'b1) begin n_bad++; $display("FAIL nosig_flag: got %b want 1", ons); end
        n_cmp++;
        if (ok !== 32'h0 || oc != 0) begin n_bad++; $display("FAIL nosig_results: k_est=%h cross_cnt=%0d want 0 0", ok, oc); end
        n_cmp++;
        if (ol != WIN || op != 1) begin n_bad++; $display("FAIL nosig_timeout: len %0d pulses %0d want %0d 1", ol, op, WIN); end
    endtask

    task automatic test_noise();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        ph = '0;
        run_meas(32'h0400_0000, 0, 4, 8, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != 16 || oc != ec) begin n_bad++; $display("FAIL noise_hyst8: got %0d want 16 (model %0d)", oc, ec); end
        ph = '0;
        run_meas(32'h0400_0000, 0, 4, 0, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != ec || oc < 16) begin n_bad++; $display("FAIL noise_hyst0: got %0d want %0d", oc, ec); end
        n_cmp++;
        if (ol != el) begin n_bad++; $display("FAIL noise_hyst0_len: got %0d want %0d", ol, el); end
    endtask

    task automatic test_hysteresis();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        run_meas(32'h0, 2, 0, 8, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (ons !== 1'b1 || oc != 0) begin n_bad++; $display("FAIL dither_hyst8: no_signal=%b cnt=%0d want 1 0", ons, oc); end
        run_meas(32'h0, 2, 0, 0, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != WIN / 2 || oc != ec) begin n_bad++; $display("FAIL dither_hyst0_cnt: got %0d want %0d", oc, WIN / 2); end
        n_cmp++;
        if (ok !== 32'h8000_0000) begin n_bad++; $display("FAIL dither_hyst0_k: got %h want 80000000", ok); end
    endtask

    task automatic test_gappy_valid();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        ph = '0;
        run_meas(32'h0400_0000, 0, 0, 8, 50, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != 16 || ok !== 32'h0400_0000) begin n_bad++; $display("FAIL gappy_result: cnt=%0d k=%h want 16 04000000", oc, ok); end
        n_cmp++;
        if (ol != el || os < (3 * WIN) / 2) begin n_bad++; $display("FAIL gappy_timing: len %0d steps %0d want len %0d", ol, os, el); end
    endtask

    task automatic test_back_to_back();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok; bit ons, ens;
        ph = '0;
        run_meas(32'h0400_0000, 0, 0, 8, 100, 1'b1, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (op != 1 || ob != 0) begin n_bad++; $display("FAIL busy_start: done pulses %0d busy errors %0d want 1 0", op, ob); end
        n_cmp++;
        if (oc != 16 || ol != el) begin n_bad++; $display("FAIL busy_start_result: cnt=%0d len=%0d want 16 %0d", oc, ol, el); end
    endtask

    task automatic test_reset_mid();
        int oc, ol, op, ob, os, ec, el, nd; logic [31:0] ok; bit ons, ens;
        ph = '0;
        step(1'b0, 10'd0, 1'b0, 9'd8, 1'b0);
        step(1'b0, 10'd0, 1'b1, 9'd8, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, wave(32'h0400_0000, 0, 0), 1'b0, 9'd8, 1'b0);
        rst_n = 1'b0; sample_valid = 1'b0; start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || k_est !== 32'h0 || cross_cnt !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: busy=%b k_est=%h cnt=%0d want 0 0 0", busy, k_est, cross_cnt);
        end
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) nd++;
        end
        rst_n = 1'b1;
        model_reset();
        n_cmp++;
        if (nd != 0) begin n_bad++; $display("FAIL midreset_done: got %0d done cycles want 0", nd); end
        ph = '0;
        run_meas(32'h0400_0000, 0, 0, 8, 100, 1'b0, oc, ok, ons, ol, op, ob, os, ec, ens, el);
        n_cmp++;
        if (oc != 16 || ok !== 32'h0400_0000 || ons !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_rerun: cnt=%0d k=%h ns=%b want 16 04000000 0", oc, ok, ons);
        end
    endtask

    task automatic test_random();
        int oc, ol, op, ob, os, ec, el; logic [31:0] ok, ek, kk; bit ons, ens;
        for (int it = 0; it < 4; it++) begin
            kk = $urandom_range(32'h0080_0000, 32'h2000_0000);
            ph = $urandom();
            run_meas(kk, 0, int'($urandom_range(6)), int'($urandom_range(30)), 60 + int'($urandom_range(40)), 1'b0,
                     oc, ok, ons, ol, op, ob, os, ec, ens, el);
            ek = 32'(ec) << (32 - G);
            n_cmp++;
            if (oc != ec || ons !== ens) begin
                n_bad++;
                $display("FAIL random_%0d_cnt: K=%h cnt=%0d ns=%b want %0d %b", it, kk, oc, ons, ec, ens);
            end
            n_cmp++;
            if (ok !== ek || ol != el || op != 1) begin
                n_bad++;
                $display("FAIL random_%0d_k: k=%h len=%0d pulses=%0d want %h %0d 1", it, ok, ol, op, ek, el);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = '0; hyst = '0;
        ph = '0; dith = 1'b0;
        model_reset();
        test_reset();
        test_clean_sine();
        test_no_signal();
        test_noise();
        test_hysteresis();
        test_gappy_valid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
